// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline sequencer and the core: stall requests,
// redirect sources, and the freeze/flush/branch controls driven back to PC and stages.
interface pipeline_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  pause_req_if;
   logic                  pause_req_id;
   logic                  pause_req_ex;
   logic                  pause_req_mem;
   logic                  branch_i;
   logic [ADDR_WIDTH-1:0] branch_target_i;
   logic                  exception_i;
   logic [ADDR_WIDTH-1:0] exception_pc_i;
   logic                  ertn_i;
   logic [ADDR_WIDTH-1:0] era_i;
   logic                  idle_i;
   logic                  interrupt_i;
   logic [5:0]            pause_o;
   logic                  flush_o;
   logic [ADDR_WIDTH-1:0] exception_handle_pc_o;
   logic                  is_branch_o;
   logic [ADDR_WIDTH-1:0] branch_target_addr_o;

   modport master (
      output pause_req_if, pause_req_id, pause_req_ex, pause_req_mem,
      output branch_i, branch_target_i, exception_i, exception_pc_i,
      output ertn_i, era_i, idle_i, interrupt_i,
      input  pause_o, flush_o, exception_handle_pc_o, is_branch_o, branch_target_addr_o
   );

   modport slave (
      input  pause_req_if, pause_req_id, pause_req_ex, pause_req_mem,
      input  branch_i, branch_target_i, exception_i, exception_pc_i,
      input  ertn_i, era_i, idle_i, interrupt_i,
      output pause_o, flush_o, exception_handle_pc_o, is_branch_o, branch_target_addr_o
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Six-stage pipeline sequencer: stall merge, redirect arbitration, branch buffering, IDLE.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_ctrl_if.slave       ctrl,
   output logic [31:0]          perf_stall_cycles_o,
   output logic [31:0]          perf_flush_cnt_o
);

   typedef enum logic [1:0] {StRun, StFlush, StIdle} state_e;

   localparam logic [1:0] FlushLast = 2'(FLUSH_CYCLES - 1);

   state_e                state_q, state_d;
   logic [1:0]            flush_cnt_q, flush_cnt_d;
   logic [ADDR_WIDTH-1:0] target_q, target_d;
   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

   logic [5:0]            stall_vec;
   logic [5:0]            pause;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_tgt;
   logic                  is_branch;
   logic [ADDR_WIDTH-1:0] branch_tgt;

   // Highest requesting stage freezes itself and everything upstream of it.
   always_comb begin
      stall_vec = 6'b000000;
      if (ctrl.pause_req_mem)     stall_vec = 6'b011111;
      else if (ctrl.pause_req_ex) stall_vec = 6'b001111;
      else if (ctrl.pause_req_id) stall_vec = 6'b000111;
      else if (ctrl.pause_req_if) stall_vec = 6'b000011;
   end

   assign redirect     = ctrl.exception_i | ctrl.ertn_i;
   assign redirect_tgt = ctrl.exception_i ? ctrl.exception_pc_i : ctrl.era_i;

   always_comb begin
      pause = 6'b000000;
      unique case (state_q)
         StRun:   pause = stall_vec;
         StIdle:  pause = 6'b000111 | stall_vec;
         StFlush: pause = 6'b000000;
         default: pause = 6'b000000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      target_d    = target_q;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      is_branch   = 1'b0;
      branch_tgt  = '0;

      if (redirect) begin
         // A redirect restarts the flush window from any state and kills any buffered branch.
         state_d     = StFlush;
         flush_cnt_d = FlushLast;
         target_d    = redirect_tgt;
         pend_d      = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (ctrl.idle_i) state_d = StIdle;
               if (pend_q) begin
                  // The older buffered branch wins; any new branch_i is wrong-path.
                  if (!pause[0]) begin
                     is_branch  = 1'b1;
                     branch_tgt = pend_tgt_q;
                     pend_d     = 1'b0;
                  end
               end else if (ctrl.branch_i) begin
                  if (!pause[0]) begin
                     is_branch  = 1'b1;
                     branch_tgt = ctrl.branch_target_i;
                  end else begin
                     pend_d     = 1'b1;
                     pend_tgt_d = ctrl.branch_target_i;
                  end
               end
            end
            StIdle: begin
               if (ctrl.interrupt_i) state_d = StRun;
            end
            StFlush: begin
               if (flush_cnt_q == 2'd0) state_d = StRun;
               else flush_cnt_d = flush_cnt_q - 2'd1;
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         flush_cnt_q <= 2'd0;
         target_q    <= '0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         target_q    <= target_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
      end
   end

   // Outputs are forced low while reset is held, even though the stall merge is combinational.
   always_comb begin
      ctrl.pause_o               = rst ? 6'b000000 : pause;
      ctrl.flush_o               = !rst && (state_q == StFlush);
      ctrl.exception_handle_pc_o = (!rst && state_q == StFlush) ? target_q : '0;
      ctrl.is_branch_o           = !rst && is_branch;
      ctrl.branch_target_addr_o  = (!rst && is_branch) ? branch_tgt : '0;
   end

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         if (ctrl.pause_o[0]) perf_stall_q <= perf_stall_q + 32'd1;
         if (redirect)        perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_flush_cnt_o    = perf_flush_q;
`else
   assign perf_stall_cycles_o = 32'd0;
   assign perf_flush_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected per-cycle outputs are queued as stimulus is
// driven and popped at the following negedge for comparison.
module tb_pipeline_ctrl;

   localparam int unsigned AW = 32;

   typedef struct {
      string       tag;
      logic [5:0]  pause;
      logic        flush;
      logic [31:0] hpc;
      logic        isb;
      logic [31:0] btgt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
   int          checks;
   int          errors;
   exp_t        sb[$];

   pipeline_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   pipeline_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(1)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ctrl                (bus.slave),
      .perf_stall_cycles_o (perf_stall),
      .perf_flush_cnt_o    (perf_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.branch_i    = 1'b0;
      bus.exception_i = 1'b0;
      bus.ertn_i      = 1'b0;
      bus.idle_i      = 1'b0;
      bus.interrupt_i = 1'b0;
   endtask

   // Queue the expectation for the cycle just driven, then compare at negedge.
   task automatic chk(input string tag, input logic [5:0] p, input logic f,
                      input logic [31:0] hpc, input logic ib, input logic [31:0] bt);
      exp_t e;
      e.tag = tag; e.pause = p; e.flush = f; e.hpc = hpc; e.isb = ib; e.btgt = bt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      cmp({e.tag, ".pause"}, 32'(bus.pause_o), 32'(e.pause));
      cmp({e.tag, ".flush"}, 32'(bus.flush_o), 32'(e.flush));
      cmp({e.tag, ".hpc"}, bus.exception_handle_pc_o, e.hpc);
      cmp({e.tag, ".isb"}, 32'(bus.is_branch_o), 32'(e.isb));
      cmp({e.tag, ".btgt"}, bus.branch_target_addr_o, e.btgt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.pause_req_if = 1'b0; bus.pause_req_id = 1'b0;
      bus.pause_req_ex = 1'b1; bus.pause_req_mem = 1'b0;
      bus.branch_target_i = 32'h0; bus.exception_pc_i = 32'h0; bus.era_i = 32'h0;
      clr();
      bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000010;
      @(posedge clk); #1;
      chk("reset", 6'b000000, 0, 0, 0, 0);
      rst = 1'b0; bus.pause_req_ex = 1'b0; clr();

      // Stall merge
      bus.pause_req_ex = 1'b1;
      chk("stall_ex", 6'b001111, 0, 0, 0, 0);
      bus.pause_req_mem = 1'b1;
      chk("stall_mem", 6'b011111, 0, 0, 0, 0);
      bus.pause_req_ex = 1'b0; bus.pause_req_mem = 1'b0; bus.pause_req_if = 1'b1;
      chk("stall_if", 6'b000011, 0, 0, 0, 0);
      bus.pause_req_if = 1'b0;
      chk("stall_none", 6'b000000, 0, 0, 0, 0);

      // Direct branch pass-through
      bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000200;
      chk("br_pass", 6'b000000, 0, 0, 1, 32'h1C000200);
      clr();

      // Exception with a simultaneous branch that must be ignored
      bus.exception_i = 1'b1; bus.exception_pc_i = 32'h1C008000;
      bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000500;
      chk("exc_n", 6'b000000, 0, 0, 0, 0);
      clr();
      chk("exc_n1", 6'b000000, 1, 32'h1C008000, 0, 0);
      chk("exc_n2", 6'b000000, 0, 0, 0, 0);

      // Exception beats ertn; then ertn alone
      bus.exception_i = 1'b1; bus.ertn_i = 1'b1; bus.era_i = 32'h1C000040;
      chk("prio_n", 6'b000000, 0, 0, 0, 0);
      clr();
      chk("prio_n1", 6'b000000, 1, 32'h1C008000, 0, 0);
      bus.ertn_i = 1'b1;
      chk("ertn_n", 6'b000000, 0, 0, 0, 0);
      clr();
      chk("ertn_n1", 6'b000000, 1, 32'h1C000040, 0, 0);
      chk("ertn_n2", 6'b000000, 0, 0, 0, 0);

      // Branch buffered under stall; younger branches dropped
      bus.pause_req_id = 1'b1;
      chk("pend_stall", 6'b000111, 0, 0, 0, 0);
      bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000100;
      chk("pend_latch", 6'b000111, 0, 0, 0, 0);
      bus.branch_target_i = 32'h1C000300;
      chk("pend_drop", 6'b000111, 0, 0, 0, 0);
      clr();
      chk("pend_hold", 6'b000111, 0, 0, 0, 0);
      bus.pause_req_id = 1'b0;
      bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000400;
      chk("pend_fire", 6'b000000, 0, 0, 1, 32'h1C000100);
      clr();
      chk("pend_clear", 6'b000000, 0, 0, 0, 0);

      // IDLE hold, interrupt wake-up, then exception
      bus.idle_i = 1'b1;
      chk("idle_n", 6'b000000, 0, 0, 0, 0);
      clr();
      for (int i = 0; i < 20; i++) chk("idle_hold", 6'b000111, 0, 0, 0, 0);
      bus.pause_req_mem = 1'b1;
      chk("idle_merge", 6'b011111, 0, 0, 0, 0);
      bus.pause_req_mem = 1'b0; bus.interrupt_i = 1'b1;
      chk("idle_wake", 6'b000111, 0, 0, 0, 0);
      clr();
      chk("idle_run", 6'b000000, 0, 0, 0, 0);
      bus.exception_i = 1'b1; bus.exception_pc_i = 32'h1C009000;
      chk("wake_exc", 6'b000000, 0, 0, 0, 0);
      clr();
      chk("wake_flush", 6'b000000, 1, 32'h1C009000, 0, 0);
      chk("wake_run", 6'b000000, 0, 0, 0, 0);

      // Exception straight out of IDLE
      bus.idle_i = 1'b1;
      chk("idle2_n", 6'b000000, 0, 0, 0, 0);
      clr();
      bus.exception_i = 1'b1; bus.exception_pc_i = 32'h1C00A000;
      chk("idle2_exc", 6'b000111, 0, 0, 0, 0);
      clr();
      chk("idle2_flush", 6'b000000, 1, 32'h1C00A000, 0, 0);
      chk("idle2_run", 6'b000000, 0, 0, 0, 0);

      // Reset during FLUSH
      bus.exception_i = 1'b1; bus.exception_pc_i = 32'h1C00B000;
      chk("rstf_exc", 6'b000000, 0, 0, 0, 0);
      clr(); rst = 1'b1;
      chk("rstf_hold", 6'b000000, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rstf_after", 6'b000000, 0, 0, 0, 0);

      // Reset clears the pending buffer
      bus.pause_req_id = 1'b1; bus.branch_i = 1'b1; bus.branch_target_i = 32'h1C000700;
      chk("rstp_latch", 6'b000111, 0, 0, 0, 0);
      clr(); rst = 1'b1;
      chk("rstp_hold", 6'b000000, 0, 0, 0, 0);
      rst = 1'b0; bus.pause_req_id = 1'b0;
      chk("rstp_empty", 6'b000000, 0, 0, 0, 0);

      // Reset during IDLE
      bus.idle_i = 1'b1;
      chk("rsti_n", 6'b000000, 0, 0, 0, 0);
      clr();
      chk("rsti_idle", 6'b000111, 0, 0, 0, 0);
      rst = 1'b1;
      chk("rsti_hold", 6'b000000, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rsti_after", 6'b000000, 0, 0, 0, 0);

      // Five stall cycles then one redirect for the performance counters
      bus.pause_req_if = 1'b1;
      for (int i = 0; i < 5; i++) chk("perf_stall", 6'b000011, 0, 0, 0, 0);
      bus.pause_req_if = 1'b0; bus.exception_i = 1'b1; bus.exception_pc_i = 32'h1C00C000;
      chk("perf_exc", 6'b000000, 0, 0, 0, 0);
      clr();
`ifdef CTRL_PERF_CNT_EN
      cmp("perf_stall_cycles", perf_stall, 32'd5);
      cmp("perf_flush_cnt", perf_flush, 32'd1);
`else
      cmp("perf_stall_tied", perf_stall, 32'd0);
      cmp("perf_flush_tied", perf_flush, 32'd0);
`endif
      chk("perf_flush", 6'b000000, 1, 32'h1C00C000, 0, 0);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_residue observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 6-stage core: PC, IF, ID, EX, MEM, WB.
- Merges per-stage stall requests into the pause[5:0] vector consumed by the PC register and the stage latches.
- Arbitrates redirect sources (exception, ertn, EX branch) into the PC's flush/branch inputs.
- Buffers branches resolved while fetch is frozen.
- Implements the IDLE wait-for-interrupt state.

Parameters:
ADDR_WIDTH, 32, width of all instruction addresses.
FLUSH_CYCLES, 1, number of cycles flush_o is held per redirect (1..3).

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
pause_req_if  in  1  IF stall request (stage 1)
pause_req_id  in  1  ID stall request (stage 2)
pause_req_ex  in  1  EX stall request (stage 3)
pause_req_mem  in  1  MEM stall request (stage 4)
branch_i  in  1  EX resolved taken branch/jump, single-cycle pulse
branch_target_i  in  ADDR_WIDTH  branch target
exception_i  in  1  commit-stage exception/interrupt, single-cycle pulse
exception_pc_i  in  ADDR_WIDTH  handler entry (eentry)
ertn_i  in  1  commit-stage ertn, single-cycle pulse
era_i  in  ADDR_WIDTH  return address
idle_i  in  1  idle instruction committed, single-cycle pulse
interrupt_i  in  1  pending, enabled interrupt (level)
pause_o  out  6  stage freeze vector; bit0=PC ... bit5=WB
flush_o  out  1  drives the PC's exception_flush and stage flushes
exception_handle_pc_o  out  ADDR_WIDTH  redirect target while flush_o is high
is_branch_o  out  1  drives the PC's is_branch_i
branch_target_addr_o  out  ADDR_WIDTH  drives the PC's branch_target_addr_i

Behaviour:
- Reset: while rst=1 all outputs are 0, state=RUN and the pending branch is cleared. Reset mid-FLUSH or mid-IDLE aborts to RUN.
- FSM states: RUN, FLUSH, IDLE.
- Stall merge (combinational, state RUN): let k be the highest requesting stage index (if=1, id=2, ex=3, mem=4). Then pause_o[k:0]=1 and the upper bits are 0. With no request, pause_o=0.
- IDLE: pause_o=6'b000111; PC, IF and ID frozen while MEM/WB drain. Stall requests are OR-merged on top.
- FLUSH: pause_o=0.
- Redirect priority is exception_i > ertn_i > idle_i; lower-priority requests in the same cycle are dropped.
- exception_i or ertn_i in any state at cycle N:
  - The target is registered.
  - From cycle N+1 the block is in FLUSH for FLUSH_CYCLES cycles.
  - flush_o=1 and exception_handle_pc_o=target during those cycles; exception_handle_pc_o=0 otherwise.
  - The pending branch is cleared. branch_i is ignored in cycle N and throughout FLUSH.
  - Then the block returns to RUN.
- idle_i in RUN: transition to IDLE next cycle.
- IDLE exit: interrupt_i=1 returns to RUN next cycle; the actual redirect arrives via exception_i. exception_i while in IDLE goes directly to FLUSH.
- Branch path, RUN only:
  - If pause_o[0]=0: is_branch_o=branch_i and branch_target_addr_o=branch_target_i, combinational, same cycle.
  - If pause_o[0]=1 while branch_i=1: the target is latched into the pending buffer.
  - While pending and pause_o[0]=0: is_branch_o=1 with the buffered target for exactly one cycle, then the buffer clears.
  - A branch_i arriving while a branch is already pending is dropped; the older branch wins because the younger one is wrong-path.
  - A pending branch has priority over a simultaneous branch_i, which is dropped.
- is_branch_o and branch_target_addr_o are 0 whenever not asserting.
- Targets are passed through unchanged; no alignment check is done here, because ADEF is raised by the PC.

Optional Feature:
Macro: CTRL_PERF_CNT_EN
- Defined: two 32-bit counters, output on extra ports perf_stall_cycles_o and perf_flush_cnt_o.
  - perf_stall_cycles_o increments every cycle pause_o[0]=1.
  - perf_flush_cnt_o increments once per redirect entry into FLUSH.
  - Both wrap at 2^32, reset to 0 on rst, and are registered.
- Undefined: both ports exist and are tied to 0; no counter flops are synthesised.

Test Plan:
1. Only pause_req_ex=1 -> pause_o=6'b001111; adding pause_req_mem=1 -> pause_o=6'b011111; releasing all -> 6'b000000.
2. exception_i=1 with exception_pc_i=32'h1C008000 and FLUSH_CYCLES=1 at cycle N -> cycle N+1: flush_o=1, exception_handle_pc_o=32'h1C008000; cycle N+2: flush_o=0. A branch_i in cycle N does not produce is_branch_o.
3. exception_i and ertn_i together with era_i=32'h1C000040 -> the target is the exception_pc_i value. ertn_i alone -> the target is 32'h1C000040.
4. pause_req_id=1, then branch_i=1 with target 32'h1C000100 -> is_branch_o=0; release the stall 3 cycles later -> is_branch_o=1 with target 32'h1C000100 for one cycle. A second branch_i during the stall is dropped.
5. idle_i=1 -> next cycle pause_o=6'b000111, held 20 cycles; interrupt_i=1 -> next cycle pause_o=0; then exception_i -> flush as in scenario 2.
6. rst=1 asserted during FLUSH and during IDLE -> the next cycle has all outputs 0 and the pending buffer empty. With CTRL_PERF_CNT_EN defined, a 5-cycle stall then one exception -> perf_stall_cycles_o=5 and perf_flush_cnt_o=1.
